arbiter_tx: RTL

//  Distributes work items from the upstream word stream to N_UNITS computing units and tracks packet

---
 rtl/arbiter_tx_pkg.sv | 23 ++
 rtl/arbiter_tx_if.sv | 26 ++
 rtl/arbiter_tx_serializer.sv | 46 ++++
 rtl/arbiter_tx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/arbiter_tx_pkg.sv
// Shared definitions for the arbiter transmit/receive pair.
// Covers FSM encoding, frame delimiters and the MSB helper macro.
`ifndef MSB
`define MSB(w) ((w) - 1)
`endif

package arbiter_tx_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_HEADER  = 3'd2,
        ST_DATA    = 3'd3,
        ST_TRAILER = 3'd4,
        ST_ACCOUNT = 3'd5,
        ST_WAIT_RX = 3'd6
    } tx_state_e;

    localparam int          WORD_W        = 16;
    localparam logic [15:0] FRAME_HEADER  = 16'hFFFF;
    localparam logic [15:0] FRAME_TRAILER = 16'h0000;

endpackage

// File: rtl/arbiter_tx_if.sv
// Item stream in, unit broadcast bus out.
// A word moves only on a cycle where in_valid and in_ready are both high; in_valid
// may not depend on in_ready, and unit_wr_en has no back-pressure (units are sized by afull).
interface arbiter_tx_if #(
    parameter int N_UNITS          = 4,
    parameter int UNIT_INPUT_WIDTH = 4
);
    logic [15:0]                 in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [15:0]                 in_pkt_id;
    logic                        in_pkt_end;
    logic [UNIT_INPUT_WIDTH-1:0] unit_in;
    logic [N_UNITS-1:0]          unit_wr_en;
    logic [N_UNITS-1:0]          unit_afull;

    modport master (
        output in_data, in_valid, in_pkt_id, in_pkt_end, unit_afull,
        input  in_ready, unit_in, unit_wr_en
    );

    modport slave (
        input  in_data, in_valid, in_pkt_id, in_pkt_end, unit_afull,
        output in_ready, unit_in, unit_wr_en
    );
endinterface

// File: rtl/arbiter_tx_serializer.sv
// Walks the item buffer word by word, emitting UNIT_INPUT_WIDTH chunks LSB first.
module arbiter_tx_serializer
    import arbiter_tx_pkg::*;
#(
    parameter int UNIT_INPUT_WIDTH = 4,
    parameter int ITEM_NUM_WORDS   = 8,
    localparam int AW = $clog2(ITEM_NUM_WORDS)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         i_en,
    input  logic [15:0]                  i_word,
    output logic [AW-1:0]                o_rd_addr,
    output logic [`MSB(UNIT_INPUT_WIDTH):0] o_chunk,
    output logic                         o_last
);
    localparam int CPW = WORD_W / UNIT_INPUT_WIDTH;
    localparam int CW  = (CPW > 1) ? $clog2(CPW) : 1;

    logic [AW-1:0] r_word;
    logic [CW-1:0] r_chunk;
    logic          w_chunk_last;
    logic          w_word_last;
    logic [15:0]   w_shift;

    assign w_chunk_last = (r_chunk == CW'(CPW - 1));
    assign w_word_last  = (r_word == AW'(ITEM_NUM_WORDS - 1));
    assign w_shift      = i_word >> (int'(r_chunk) * UNIT_INPUT_WIDTH);
    assign o_chunk      = w_shift[UNIT_INPUT_WIDTH-1:0];
    assign o_rd_addr    = r_word;
    assign o_last       = w_chunk_last & w_word_last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_word  <= '0;
            r_chunk <= '0;
        end else if (i_en) begin
            if (w_chunk_last) begin
                r_chunk <= '0;
                r_word  <= w_word_last ? '0 : r_word + 1'b1;
            end else begin
                r_chunk <= r_chunk + 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbiter_tx.sv
// Buffers one item, picks a ready unit round-robin, and sends it framed by
// header/trailer chunks; keeps per-packet accounting for the receive side.
module arbiter_tx
    import arbiter_tx_pkg::*;
#(
    parameter int N_UNITS          = 4,
    parameter int UNIT_INPUT_WIDTH = 4,
    parameter int ITEM_NUM_WORDS   = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    arbiter_tx_if.slave      bus,
    output logic [31:0]      num_processed_tx,
    output logic [15:0]      pkt_id_tx,
    output logic             pkt_tx_done,
    input  logic             pkt_rx_done,
    output logic             err,
    output tx_state_e        o_dbg_state
);
    localparam int PTR_W = $clog2(N_UNITS);
    localparam int AW    = $clog2(ITEM_NUM_WORDS);

    tx_state_e                   r_state, w_next;
    logic [PTR_W-1:0]            r_ptr;
    logic [N_UNITS-1:0]          r_afull;
    logic                        r_phase;
    logic [AW-1:0]               r_wr_addr;
    logic                        r_first_item;
    logic                        r_pkt_end;
    logic                        r_in_ready;
    logic [15:0]                 r_ram [ITEM_NUM_WORDS];

    logic                        w_accept;
    logic                        w_last_word;
    logic [PTR_W-1:0]            w_ptr_inc;
    logic [N_UNITS-1:0]          w_onehot;
    logic [AW-1:0]               w_rd_addr;
    logic [UNIT_INPUT_WIDTH-1:0] w_chunk;
    logic                        w_ser_last;
    logic                        w_ser_en;
    logic [UNIT_INPUT_WIDTH-1:0] w_unit_in;
    logic [N_UNITS-1:0]          w_wr_en;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_last_word = (r_wr_addr == AW'(ITEM_NUM_WORDS - 1));
    assign w_ptr_inc   = (r_ptr == PTR_W'(N_UNITS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_onehot    = N_UNITS'(1) << r_ptr;

    assign bus.in_ready   = r_in_ready;
    assign bus.unit_in    = w_unit_in;
    assign bus.unit_wr_en = w_wr_en;
    assign o_dbg_state    = r_state;

    arbiter_tx_serializer #(
        .UNIT_INPUT_WIDTH (UNIT_INPUT_WIDTH),
        .ITEM_NUM_WORDS   (ITEM_NUM_WORDS)
    ) u_ser (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_en      (w_ser_en),
        .i_word    (r_ram[w_rd_addr]),
        .o_rd_addr (w_rd_addr),
        .o_chunk   (w_chunk),
        .o_last    (w_ser_last)
    );

    always_ff @(posedge CLK) begin
        if (w_accept) r_ram[r_wr_addr] <= bus.in_data;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_unit_in = '0;
        w_wr_en   = '0;
        w_ser_en  = 1'b0;
        case (r_state)
            ST_LOAD:    if (w_accept && w_last_word) w_next = ST_SELECT;
            ST_SELECT:  if (!r_afull[r_ptr]) w_next = ST_HEADER;
            ST_HEADER: begin
                w_unit_in = FRAME_HEADER[UNIT_INPUT_WIDTH-1:0];
                w_wr_en   = w_onehot;
                w_next    = ST_DATA;
            end
            ST_DATA: begin
                w_unit_in = w_chunk;
                w_wr_en   = w_onehot;
                w_ser_en  = 1'b1;
                if (w_ser_last) w_next = ST_TRAILER;
            end
            ST_TRAILER: begin
                w_unit_in = FRAME_TRAILER[UNIT_INPUT_WIDTH-1:0];
                w_wr_en   = w_onehot;
                w_next    = ST_ACCOUNT;
            end
            ST_ACCOUNT: w_next = r_pkt_end ? ST_WAIT_RX : ST_LOAD;
            ST_WAIT_RX: if (pkt_rx_done) w_next = ST_LOAD;
            default:    w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_in_ready       <= 1'b0;
            r_ptr            <= '0;
            r_afull          <= '0;
            r_phase          <= 1'b0;
            r_wr_addr        <= '0;
            r_first_item     <= 1'b1;
            r_pkt_end        <= 1'b0;
            num_processed_tx <= '0;
            pkt_id_tx        <= '0;
            pkt_tx_done      <= 1'b0;
            err              <= 1'b0;
        end else begin
            r_in_ready <= (w_next == ST_LOAD);
            r_afull    <= bus.unit_afull;
            if (w_accept) begin
                r_wr_addr <= w_last_word ? '0 : r_wr_addr + 1'b1;
                if (r_first_item && r_wr_addr == '0) pkt_id_tx <= bus.in_pkt_id;
                if (w_last_word) r_pkt_end <= bus.in_pkt_end;
            end
            // Busy units are skipped at one unit every two cycles, matching arbiter_rx.
            if (r_state == ST_SELECT && r_afull[r_ptr]) begin
                r_phase <= ~r_phase;
                if (r_phase) r_ptr <= w_ptr_inc;
            end else begin
                r_phase <= 1'b0;
            end
            if (r_state == ST_TRAILER) r_ptr <= w_ptr_inc;
            if (r_state == ST_ACCOUNT) begin
                num_processed_tx <= num_processed_tx + 32'd1;
                r_first_item     <= r_pkt_end;
                if (r_pkt_end) pkt_tx_done <= 1'b1;
            end
            if (r_state == ST_WAIT_RX && pkt_rx_done) begin
                num_processed_tx <= '0;
                pkt_tx_done      <= 1'b0;
            end
            if (pkt_rx_done && r_state != ST_WAIT_RX) err <= 1'b1;
        end
    end
endmodule
